tty_transmitter: RTL

Teletype serial transmitter for the PDP-8/I console interface, at device code 04. It accepts IOT pulses and AC bits from the processor and loads an 8-bit character buffer. The character is shifted out as an asynchronous serial frame: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits. Bit timing comes from the shared 8x-baud tick. The block raises the printer flag, the skip and the interrupt request toward the processor.

---
 rtl/tty_transmitter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tty_transmitter.sv
// Teletype serial transmitter (PDP-8/I console printer, TLS/TPC/TSF/TCF).
// Frames: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits,
// each bit cell TICKS_PER_BIT clk_8baud strobes long.
module tty_transmitter #(
  parameter logic [5:0]  DEV_CODE      = 6'o04,
  parameter int unsigned STOP_BITS     = 2,
  parameter int unsigned TICKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] dev_sel,
  input  logic       iop1,
  input  logic       iop2,
  input  logic       iop4,
  input  logic [7:0] ac,
  input  logic       io_clr,
  input  logic       clk_8baud,
  output logic       ser_out,
  output logic       flag,
  output logic       io_skip_n,
  output logic       int_req_n,
  output logic       busy
);

  localparam int unsigned TW         = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int unsigned STOP_TICKS = STOP_BITS * TICKS_PER_BIT;
  localparam int unsigned SW         = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic            ser_q, ser_nxt;
  logic            flag_q, flag_nxt;
  logic            busy_q, busy_nxt;
  logic            pending, pending_nxt;
  logic [7:0]      buffer, buffer_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [TW-1:0]   tick_cnt, tick_nxt;
  logic [2:0]      bit_cnt, bit_nxt;
  logic [SW-1:0]   stop_cnt, stop_nxt;
  logic            sel;

  assign sel       = (dev_sel == DEV_CODE);
  assign ser_out   = ser_q;
  assign flag      = flag_q;
  assign busy      = busy_q;
  assign int_req_n = ~flag_q;
  assign io_skip_n = ~(sel & iop1 & flag_q);

  // Next-state and datapath: FSM first, then IOT load, then io_clr override.
  // Load is applied after the FSM so a load coinciding with the frame-end
  // consumption of pending re-arms pending rather than being lost; the flag
  // clear is applied before the FSM so an end-of-frame set wins over TCF.
  always_comb begin
    state_nxt   = state;
    ser_nxt     = ser_q;
    flag_nxt    = flag_q;
    busy_nxt    = busy_q;
    pending_nxt = pending;
    buffer_nxt  = buffer;
    shreg_nxt   = shreg;
    tick_nxt    = tick_cnt;
    bit_nxt     = bit_cnt;
    stop_nxt    = stop_cnt;

    if (sel && iop2) flag_nxt = 1'b0;

    case (state)
      IDLE: begin
        ser_nxt = 1'b1;
        if (clk_8baud && pending) begin
          shreg_nxt   = buffer;
          pending_nxt = 1'b0;
          ser_nxt     = 1'b0;
          tick_nxt    = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (clk_8baud) begin
          if (tick_cnt == TICK_LAST) begin
            ser_nxt   = shreg[0];
            bit_nxt   = '0;
            tick_nxt  = '0;
            state_nxt = DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (clk_8baud) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            shreg_nxt = {1'b0, shreg[7:1]};
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              ser_nxt   = 1'b1;
              stop_nxt  = '0;
              state_nxt = STOP;
            end else begin
              ser_nxt = shreg[1];
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (clk_8baud) begin
          if (stop_cnt == STOP_LAST) begin
            flag_nxt = 1'b1;
            if (pending) begin
              shreg_nxt   = buffer;
              pending_nxt = 1'b0;
              ser_nxt     = 1'b0;
              tick_nxt    = '0;
              state_nxt   = START;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = IDLE;
            end
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (sel && iop4) begin
      buffer_nxt  = ac;
      pending_nxt = 1'b1;
      busy_nxt    = 1'b1;
    end

    if (io_clr) begin
      state_nxt   = IDLE;
      ser_nxt     = 1'b1;
      flag_nxt    = 1'b0;
      busy_nxt    = 1'b0;
      pending_nxt = 1'b0;
      shreg_nxt   = '0;
      tick_nxt    = '0;
      bit_nxt     = '0;
      stop_nxt    = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ser_q    <= 1'b1;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      pending  <= 1'b0;
      buffer   <= '0;
      shreg    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ser_q    <= ser_nxt;
      flag_q   <= flag_nxt;
      busy_q   <= busy_nxt;
      pending  <= pending_nxt;
      buffer   <= buffer_nxt;
      shreg    <= shreg_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
    end
  end

endmodule
